// File: rtl/damage_resolver_pkg.sv
// Shared constants for the damage resolver: player state encodings, health and
// damage amounts, hitstun/KO frame counts, winner codes, round FSM states.
// No ports. Optional feature macro used by the bundle: CHIP_DAMAGE_EN.
package damage_resolver_pkg;

   localparam int STATE_DEPTH    = 4;
   localparam int HEALTH_DEPTH   = 8;
   localparam int MAX_HEALTH     = 100;
   localparam int KICK_DAMAGE    = 12;
   localparam int GRAB_DAMAGE    = 18;
   localparam int HITSTUN_FRAMES = 20;
   localparam int KO_HOLD_FRAMES = 120;

   localparam int HITSTUN_W = 5;   // holds HITSTUN_FRAMES
   localparam int KO_CNT_W  = 7;   // holds KO_HOLD_FRAMES-1

   // Player state encodings shared with the hit calculator
   localparam logic [STATE_DEPTH-1:0] PS_IDLE  = 4'd0;
   localparam logic [STATE_DEPTH-1:0] PS_WALK  = 4'd1;
   localparam logic [STATE_DEPTH-1:0] PS_KICK  = 4'd2;
   localparam logic [STATE_DEPTH-1:0] PS_GRAB  = 4'd3;
   localparam logic [STATE_DEPTH-1:0] PS_BLOCK = 4'd4;

   localparam logic [HEALTH_DEPTH-1:0] HEALTH_FULL = 8'(MAX_HEALTH);
   localparam logic [HEALTH_DEPTH-1:0] DMG_KICK    = 8'(KICK_DAMAGE);
   localparam logic [HEALTH_DEPTH-1:0] DMG_GRAB    = 8'(GRAB_DAMAGE);
   localparam logic [HEALTH_DEPTH-1:0] DMG_CHIP    = 8'd1;
   localparam logic [HITSTUN_W-1:0]    STUN_LOAD   = 5'(HITSTUN_FRAMES);
   localparam logic [KO_CNT_W-1:0]     KO_LAST     = 7'(KO_HOLD_FRAMES - 1);

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   typedef enum logic [1:0] {RS_IDLE, RS_FIGHT, RS_KO, RS_DONE} round_state_t;

   // Health minus damage, clamped at zero; the extra bit catches the borrow.
   function automatic logic [HEALTH_DEPTH-1:0] sat_sub(input logic [HEALTH_DEPTH-1:0] h,
                                                       input logic [HEALTH_DEPTH-1:0] d);
      logic [HEALTH_DEPTH:0] diff;
      diff = {1'b0, h} - {1'b0, d};
      return diff[HEALTH_DEPTH] ? '0 : diff[HEALTH_DEPTH-1:0];
   endfunction

endpackage

// File: rtl/damage_resolver_player_damage_ctrl.sv
// Per-defender damage control: health, hitstun counter, and the attacker's
// once-per-frame "used" latch. Latency 1 clock connect->health/hit. No backpressure.
// Ports: clk, reset (async high), frame_tick, round_start, fight (round FSM in FIGHT),
//   att_connects/att_state/att_stunned (attacker side), def_state, health, stunned,
//   hit (1-clock pulse), zero_next (health becomes 0 on this clock).
// Macro CHIP_DAMAGE_EN: a blocked kick deals 1 damage and pulses hit.
module player_damage_ctrl
   import damage_resolver_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    round_start,
   input  logic                    fight,
   input  logic                    att_connects,
   input  logic [STATE_DEPTH-1:0]  att_state,
   input  logic                    att_stunned,
   input  logic [STATE_DEPTH-1:0]  def_state,
   output logic [HEALTH_DEPTH-1:0] health,
   output logic                    stunned,
   output logic                    hit,
   output logic                    zero_next
);

   logic [HITSTUN_W-1:0]    stun_cnt;
   logic                    used;
   logic                    accept;
   logic [HEALTH_DEPTH-1:0] dmg;
   logic                    dmg_pulse;
   logic                    stun_set;
   logic [HEALTH_DEPTH-1:0] health_nxt;

   assign stunned = (stun_cnt != '0);

   // Evaluated on registered (pre-tick, pre-hit) values, so a same-clock trade
   // sees both defenders unstunned and a same-clock tick cannot suppress it.
   assign accept = fight && !round_start && att_connects && !used && !att_stunned && !stunned;

   always_comb begin
      dmg       = '0;
      dmg_pulse = 1'b0;
      stun_set  = 1'b0;
      case (att_state)
         PS_KICK: begin
            if (def_state == PS_BLOCK) begin
`ifdef CHIP_DAMAGE_EN
               dmg       = DMG_CHIP;
               dmg_pulse = 1'b1;
`else
               dmg       = '0;
`endif
            end else begin
               dmg       = DMG_KICK;
               dmg_pulse = 1'b1;
               stun_set  = 1'b1;
            end
         end
         PS_GRAB: begin
            dmg       = DMG_GRAB;
            dmg_pulse = 1'b1;
            stun_set  = 1'b1;
         end
         default: ;
      endcase
   end

   assign health_nxt = accept ? sat_sub(health, dmg) : health;
   assign zero_next  = (health_nxt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         health   <= HEALTH_FULL;
         stun_cnt <= '0;
         used     <= 1'b0;
         hit      <= 1'b0;
      end else begin
         hit <= accept && dmg_pulse;
         if (round_start) begin
            // Fresh round: the attacker may land a hit straight away.
            health   <= HEALTH_FULL;
            stun_cnt <= '0;
            used     <= 1'b0;
         end else begin
            health <= health_nxt;
            if (accept && stun_set)
               stun_cnt <= STUN_LOAD;
            else if (frame_tick && stun_cnt != '0)
               stun_cnt <= stun_cnt - 1'b1;
            // Accept's set wins over the tick's clear.
            if (accept)
               used <= 1'b1;
            else if (frame_tick)
               used <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/damage_resolver.sv
// Damage resolver top: round FSM (IDLE/FIGHT/KO/DONE), KO hold counter, winner,
// plus one player_damage_ctrl per defender. Latency 1 clock connect->outputs.
// No backpressure; connects are levels sampled every clock.
// Ports: clk, reset (async high), frame_tick, round_start, p1/p2_connects,
//   p1/p2_state, p1/p2_health, p1/p2_hitstun, p1/p2_hit, round_over, winner.
// Macro CHIP_DAMAGE_EN (in player_damage_ctrl): blocked kicks deal chip damage.
module damage_resolver
   import damage_resolver_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    round_start,
   input  logic                    p1_connects,
   input  logic                    p2_connects,
   input  logic [STATE_DEPTH-1:0]  p1_state,
   input  logic [STATE_DEPTH-1:0]  p2_state,
   output logic [HEALTH_DEPTH-1:0] p1_health,
   output logic [HEALTH_DEPTH-1:0] p2_health,
   output logic                    p1_hitstun,
   output logic                    p2_hitstun,
   output logic                    p1_hit,
   output logic                    p2_hit,
   output logic                    round_over,
   output logic [1:0]              winner
);

   round_state_t        state;
   logic [KO_CNT_W-1:0] ko_cnt;
   logic                fight;
   logic                p1_zero;
   logic                p2_zero;

   assign fight = (state == RS_FIGHT);

   // Defender P1, attacked by P2
   player_damage_ctrl u_p1 (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .round_start  (round_start),
      .fight        (fight),
      .att_connects (p2_connects),
      .att_state    (p2_state),
      .att_stunned  (p2_hitstun),
      .def_state    (p1_state),
      .health       (p1_health),
      .stunned      (p1_hitstun),
      .hit          (p1_hit),
      .zero_next    (p1_zero)
   );

   // Defender P2, attacked by P1
   player_damage_ctrl u_p2 (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .round_start  (round_start),
      .fight        (fight),
      .att_connects (p1_connects),
      .att_state    (p1_state),
      .att_stunned  (p1_hitstun),
      .def_state    (p2_state),
      .health       (p2_health),
      .stunned      (p2_hitstun),
      .hit          (p2_hit),
      .zero_next    (p2_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RS_IDLE;
         ko_cnt     <= '0;
         round_over <= 1'b0;
         winner     <= WIN_NONE;
      end else if (round_start) begin
         state      <= RS_FIGHT;
         ko_cnt     <= '0;
         round_over <= 1'b0;
         winner     <= WIN_NONE;
      end else begin
         case (state)
            RS_FIGHT: begin
               if (p1_zero || p2_zero) begin
                  state      <= RS_KO;
                  ko_cnt     <= '0;
                  round_over <= 1'b1;
                  // {p1_zero,p2_zero} is exactly the winner code: 01 P1, 10 P2, 11 draw
                  winner     <= {p1_zero, p2_zero};
               end
            end
            RS_KO: begin
               if (frame_tick) begin
                  if (ko_cnt == KO_LAST)
                     state <= RS_DONE;
                  else
                     ko_cnt <= ko_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_damage_resolver.sv
// Directed self-checking bench for damage_resolver.
module tb_damage_resolver;
   import damage_resolver_pkg::*;

   logic                    clk;
   logic                    reset;
   logic                    frame_tick;
   logic                    round_start;
   logic                    p1_connects;
   logic                    p2_connects;
   logic [STATE_DEPTH-1:0]  p1_state;
   logic [STATE_DEPTH-1:0]  p2_state;
   logic [HEALTH_DEPTH-1:0] p1_health;
   logic [HEALTH_DEPTH-1:0] p2_health;
   logic                    p1_hitstun;
   logic                    p2_hitstun;
   logic                    p1_hit;
   logic                    p2_hit;
   logic                    round_over;
   logic [1:0]              winner;

   int tests = 0;
   int fails = 0;

`ifdef CHIP_DAMAGE_EN
   localparam int CHIP = 1;
`else
   localparam int CHIP = 0;
`endif

   damage_resolver dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .round_start (round_start),
      .p1_connects (p1_connects),
      .p2_connects (p2_connects),
      .p1_state    (p1_state),
      .p2_state    (p2_state),
      .p1_health   (p1_health),
      .p2_health   (p2_health),
      .p1_hitstun  (p1_hitstun),
      .p2_hitstun  (p2_hitstun),
      .p1_hit      (p1_hit),
      .p2_hit      (p2_hit),
      .round_over  (round_over),
      .winner      (winner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n clocks; leaves time 1 unit past the last rising edge.
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         cycles(1);
         frame_tick = 1'b0;
         cycles(1);
      end
   endtask

   task automatic start_round();
      round_start = 1'b1;
      cycles(1);
      round_start = 1'b0;
   endtask

   initial begin
      int n_hit;
      int hb;
      reset = 1'b1; frame_tick = 1'b0; round_start = 1'b0;
      p1_connects = 1'b0; p2_connects = 1'b0;
      p1_state = PS_IDLE; p2_state = PS_IDLE;
      cycles(2);

      // Reset state
      chk("rst_p1_health", p1_health, 100);
      chk("rst_p2_health", p2_health, 100);
      chk("rst_hitstun", {p1_hitstun, p2_hitstun}, 0);
      chk("rst_hits", {p1_hit, p2_hit}, 0);
      chk("rst_round_over", round_over, 0);
      chk("rst_winner", winner, 0);
      chk("rst_state", dut.state, RS_IDLE);
      reset = 1'b0;
      cycles(1);

      // Connects in IDLE do nothing
      p1_state = PS_KICK; p1_connects = 1'b1;
      cycles(3);
      chk("idle_ignore", p2_health, 100);
      p1_connects = 1'b0;
      start_round();
      chk("start_state", dut.state, RS_FIGHT);

      // Kick held 500 clocks in one frame: single hit
      p1_connects = 1'b1;
      cycles(1);
      chk("kick_hit_pulse", p2_hit, 1);
      chk("kick_health", p2_health, 88);
      chk("kick_stun", p2_hitstun, 1);
      n_hit = int'(p2_hit);
      for (int i = 1; i < 500; i++) begin
         cycles(1);
         n_hit += int'(p2_hit);
      end
      chk("kick_one_pulse", n_hit, 1);
      chk("kick_health_hold", p2_health, 88);
      p1_connects = 1'b0;
      frames(19);
      chk("stun_19", p2_hitstun, 1);
      frames(1);
      chk("stun_20", p2_hitstun, 0);
      chk("p1_untouched", p1_health, 100);

      // Grab on a blocker, then a blocked kick
      start_round();
      chk("reload", p2_health, 100);
      p1_state = PS_GRAB; p2_state = PS_BLOCK; p1_connects = 1'b1;
      cycles(1);
      p1_connects = 1'b0;
      chk("grab_block_health", p2_health, 82);
      chk("grab_block_stun", p2_hitstun, 1);
      frames(20);
      chk("grab_stun_done", p2_hitstun, 0);
      p1_state = PS_KICK; p1_connects = 1'b1;
      cycles(1);
      hb = 82 - CHIP;
      chk("blocked_kick_health", p2_health, hb);
      chk("blocked_kick_pulse", p2_hit, CHIP);
      chk("blocked_kick_nostun", p2_hitstun, 0);
      cycles(3);
      chk("blocked_kick_used", dut.u_p2.used, 1);
      chk("blocked_kick_once", p2_health, hb);
      p1_connects = 1'b0;
      frames(1);

      // Stunned attacker cannot hit, stunned defender is invulnerable
      p1_state = PS_IDLE; p2_state = PS_KICK; p2_connects = 1'b1;
      cycles(1);
      p2_connects = 1'b0;
      chk("p2_kick_p1", p1_health, 88);
      chk("p1_stunned", p1_hitstun, 1);
      frames(1);
      p1_state = PS_KICK; p1_connects = 1'b1; p2_connects = 1'b1;
      cycles(3);
      chk("stunned_def_safe", p1_health, 88);
      chk("stunned_att_nohit", p2_health, hb);
      chk("stunned_no_pulse", {p1_hit, p2_hit}, 0);
      p1_connects = 1'b0; p2_connects = 1'b0;
      frames(20);
      chk("p1_stun_done", p1_hitstun, 0);

      // Frame tick on the accept clock: hit lands, used ends set, full stun
      p2_state = PS_IDLE;
      frame_tick = 1'b1; p1_connects = 1'b1;
      cycles(1);
      frame_tick = 1'b0; p1_connects = 1'b0;
      chk("tick_accept_health", p2_health, hb - 12);
      chk("tick_accept_pulse", p2_hit, 1);
      chk("tick_accept_used", dut.u_p2.used, 1);
      frames(19);
      chk("tick_stun_19", p2_hitstun, 1);
      frames(1);
      chk("tick_stun_20", p2_hitstun, 0);

      // KO of P2: saturation, winner P1, frozen health, DONE timing
      start_round();
      p1_state = PS_GRAB;
      for (int i = 0; i < 5; i++) begin
         p1_connects = 1'b1;
         cycles(1);
         p1_connects = 1'b0;
         frames(20);
      end
      chk("p2_at_10", p2_health, 10);
      p1_state = PS_KICK; p1_connects = 1'b1;
      cycles(1);
      chk("ko_sat", p2_health, 0);
      chk("ko_pulse", p2_hit, 1);
      chk("ko_round_over", round_over, 1);
      chk("ko_winner", winner, WIN_P1);
      chk("ko_state", dut.state, RS_KO);
      p2_state = PS_KICK; p2_connects = 1'b1;
      cycles(3);
      chk("ko_frozen_p1", p1_health, 100);
      chk("ko_no_pulse", p1_hit, 0);
      p1_connects = 1'b0; p2_connects = 1'b0;
      frames(119);
      chk("ko_119", dut.state, RS_KO);
      frames(1);
      chk("done_120", dut.state, RS_DONE);
      chk("done_round_over", round_over, 1);
      chk("done_winner", winner, WIN_P1);
      chk("done_health", p2_health, 0);
      chk("done_stun_decayed", p2_hitstun, 0);

      // Trades down to a double KO
      start_round();
      chk("restart_winner", winner, WIN_NONE);
      chk("restart_round_over", round_over, 0);
      chk("restart_health", {p1_health, p2_health}, {8'd100, 8'd100});
      p1_state = PS_GRAB; p2_state = PS_GRAB;
      for (int i = 0; i < 5; i++) begin
         p1_connects = 1'b1; p2_connects = 1'b1;
         cycles(1);
         p1_connects = 1'b0; p2_connects = 1'b0;
         if (i == 0) begin
            chk("trade_pulses", {p1_hit, p2_hit}, 2'b11);
            chk("trade_health", {p1_health, p2_health}, {8'd82, 8'd82});
         end
         frames(20);
      end
      chk("trade_at_10", {p1_health, p2_health}, {8'd10, 8'd10});
      p1_state = PS_KICK; p2_state = PS_KICK;
      p1_connects = 1'b1; p2_connects = 1'b1;
      cycles(1);
      p1_connects = 1'b0; p2_connects = 1'b0;
      chk("draw_health", {p1_health, p2_health}, 0);
      chk("draw_pulses", {p1_hit, p2_hit}, 2'b11);
      chk("draw_winner", winner, WIN_DRAW);
      chk("draw_round_over", round_over, 1);

      // Async reset in KO
      frames(3);
      reset = 1'b1;
      #2;
      chk("arst_health", {p1_health, p2_health}, {8'd100, 8'd100});
      chk("arst_round_over", round_over, 0);
      chk("arst_winner", winner, WIN_NONE);
      chk("arst_state", dut.state, RS_IDLE);
      cycles(1);
      reset = 1'b0;
      p1_state = PS_KICK; p2_state = PS_IDLE; p1_connects = 1'b1;
      cycles(3);
      chk("arst_ignore", p2_health, 100);
      p1_connects = 1'b0;
      start_round();
      p1_connects = 1'b1;
      cycles(1);
      p1_connects = 1'b0;
      chk("arst_resume", p2_health, 88);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
